perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Parametrised performance-monitor block for the pipelined MIPS core, replacing the three fixed counters (total, stall, flush cycles).
- Counts elapsed run cycles plus NUM_EVENTS independent event inputs (stall, flush, branch, load-use, etc.).
- Start, pause and halt are controlled through a small state machine.
- Supports an atomic snapshot into shadow registers, saturating or wrapping overflow, and a registered indexed readout port for the testbench or an MMIO bus.

Parameters:
NUM_EVENTS, 4, number of event counter channels (1..15)
CNT_WIDTH, 32, width of every counter and shadow register (4..64)
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to zero
SEL_W (localparam), clog2(NUM_EVENTS+1), width of rd_sel

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; high = count, low = pause
clear  in  1  synchronous clear of all counters, flags and state
halt_in  in  1  program-done indication (e.g. LED end pattern); freezes counting
event_in  in  NUM_EVENTS  per-channel event strobes, sampled each cycle
snapshot_req  in  1  copy live counters into shadow registers
rd_sel  in  SEL_W  readout index: 0 = cycle counter, i = event channel i-1
rd_snap  in  1  1 = read shadow value, 0 = read live value
rd_data  out  CNT_WIDTH  registered readout
snap_valid  out  1  shadow registers hold a valid snapshot
overflow  out  NUM_EVENTS+1  sticky overflow per counter; bit 0 = cycle counter
running  out  1  high while state is RUN

Behaviour:
- Async reset (rst_n low):
  - All counters, shadows and rd_data go to 0.
  - overflow = 0, snap_valid = 0, running = 0, state = IDLE.
  - Reset takes effect immediately, including mid-run.
- States:
  - IDLE: enable=1 -> RUN. halt_in is ignored.
  - RUN: clear=1 -> IDLE. Otherwise halt_in=1 -> HALTED. Otherwise enable=0 -> IDLE (pause; counts retained).
  - HALTED: counts frozen; enable is ignored. Only clear or reset exits, both to IDLE.
- running is registered; it equals (state == RUN).
- Counting happens only in cycles where the state is RUN and clear=0:
  - cycle counter += 1;
  - event counter i += 1 when event_in[i] = 1.
- The cycle in which halt_in rises during RUN is counted. Counting stops from the next cycle.
- The cycle in which enable rises in IDLE is not counted. The first count occurs on the following edge.
- Overflow, when a counter at all-ones increments:
  - SATURATE=1: the counter holds at all-ones.
  - SATURATE=0: the counter wraps to 0.
  - In both modes the corresponding overflow bit is set and stays set until clear or reset.
- clear has priority over all other inputs. In the same edge it:
  - zeroes the live counters and overflow;
  - zeroes snap_valid (shadows may keep stale data but are unreadable as valid);
  - drops the state to IDLE.
- clear and enable together: the state stays IDLE for that edge; enable is honoured on the next edge.
- Snapshot:
  - On an edge with snapshot_req=1 and clear=0, each shadow register loads the value its live counter takes on that same edge, i.e. including that cycle's increment.
  - snap_valid goes to 1 on the same edge.
  - Allowed in any state.
  - A later snapshot overwrites the earlier one.
- Readout:
  - rd_data is registered, latency 1 cycle: on each edge it loads the selected value (rd_snap ? shadow[rd_sel] : live[rd_sel]).
  - rd_sel > NUM_EVENTS returns 0.
  - A live read returns the value after that edge's update.
- All arithmetic is unsigned CNT_WIDTH. There is no cross-channel carry.

Test Plan:
1. Reset; enable=1 for 10 edges counted; event_in[0]=1 every cycle, event_in[1]=1 on alternate cycles -> cycles=10, ev0=10, ev1=5, ev2=ev3=0, running=1, overflow=0.
2. During RUN, pulse halt_in for 1 cycle, then keep events toggling for 5 more cycles -> counts include the halt cycle then stay frozen; running=0; enable toggles have no effect until clear.
3. CNT_WIDTH=4, SATURATE=1, 20 event_in[0] pulses -> ev0=15, overflow[1]=1. Rerun with SATURATE=0 -> ev0=4 (20 mod 16), overflow[1]=1. Clear -> ev0=0, overflow=0.
4. snapshot_req at cycle 6 of a run with event_in[2] constant 1; run 10 more cycles -> rd_snap=1, rd_sel=3 reads 6 steady; rd_snap=0 reads 16; snap_valid=1.
5. clear and snapshot_req asserted in the same cycle -> counters 0, snap_valid=0, state IDLE. rd_sel=NUM_EVENTS+1 -> rd_data=0 one cycle later.
6. Assert rst_n low asynchronously mid-cycle during RUN -> all outputs 0 immediately, before the next clk edge. After release, enable restarts counting from 0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// Performance-monitor counter bank for the pipelined MIPS core.
// Counter 0 counts elapsed run cycles; counters 1..NUM_EVENTS count the
// strobes on event_in[0..NUM_EVENTS-1]. A small IDLE/RUN/HALTED state
// machine gates counting, a snapshot copies the live counters into shadow
// registers atomically, and rd_data is a registered indexed readout.
//
// Control handshake: there is no valid/ready pair on this block. Every input
// is sampled on each rising edge, and every output is a register updated on
// that edge. rd_data always reflects the selection presented one edge
// earlier (fixed one-cycle latency, no stall), so a reader simply holds
// rd_sel/rd_snap for one edge and takes rd_data after it.

module perf_counter_bank #(
   parameter int NUM_EVENTS = 4,
   parameter int CNT_WIDTH  = 32,
   parameter bit SATURATE   = 1'b1,
   localparam int SEL_W     = $clog2(NUM_EVENTS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  halt_in,
   input  logic [NUM_EVENTS-1:0] event_in,
   input  logic                  snapshot_req,
   input  logic [SEL_W-1:0]      rd_sel,
   input  logic                  rd_snap,
   output logic [CNT_WIDTH-1:0]  rd_data,
   output logic                  snap_valid,
   output logic [NUM_EVENTS:0]   overflow,
   output logic                  running
);

   // Counter 0 is the cycle counter; counter i is event channel i-1.
   localparam int NC = NUM_EVENTS + 1;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   // Value a counter takes when it increments past all-ones.
   localparam logic [CNT_WIDTH-1:0] CNT_OVF  = {CNT_WIDTH{SATURATE}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t               state;

   logic [CNT_WIDTH-1:0] live        [NC];
   logic [CNT_WIDTH-1:0] live_next   [NC];
   logic [CNT_WIDTH-1:0] shadow      [NC];
   logic [CNT_WIDTH-1:0] shadow_next [NC];
   logic [NC-1:0]        hit;
   logic [NC-1:0]        ovf_set;
   logic                 count_en;
   logic                 snap_take;
   logic [CNT_WIDTH-1:0] rd_next;

   // Counting and snapshots both yield to clear; the cycle counter always
   // "hits" while counting, the event counters hit on their strobe.
   assign count_en  = (state == ST_RUN) && !clear;
   assign snap_take = snapshot_req && !clear;
   assign hit       = {event_in, 1'b1};

   // Run-control state machine; running is registered alongside the state
   // so it always equals (state == ST_RUN).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         running <= 1'b0;
      end else if (clear) begin
         // clear wins over enable and halt_in on the same edge.
         state   <= ST_IDLE;
         running <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (halt_in) begin
                  state   <= ST_HALTED;
                  running <= 1'b0;
               end else if (!enable) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end
            end
            ST_HALTED: begin
               // Frozen until clear or reset.
               state   <= ST_HALTED;
               running <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   // Next live value per counter, including overflow handling; the shadow
   // copy takes the post-increment value so a snapshot is atomic.
   always_comb begin
      for (int i = 0; i < NC; i++) begin
         live_next[i] = live[i];
         ovf_set[i]   = 1'b0;
         if (clear) begin
            live_next[i] = '0;
         end else if (count_en && hit[i]) begin
            if (&live[i]) begin
               ovf_set[i]   = 1'b1;
               live_next[i] = CNT_OVF;
            end else begin
               live_next[i] = live[i] + CNT_ONE;
            end
         end
         shadow_next[i] = snap_take ? live_next[i] : shadow[i];
      end
   end

   // Readout mux; selecting past the last channel reads as zero.
   always_comb begin
      rd_next = '0;
      if (int'(rd_sel) < NC) begin
         rd_next = rd_snap ? shadow_next[rd_sel] : live_next[rd_sel];
      end
   end

   // Counter, shadow, flag and readout registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NC; i++) begin
            live[i]   <= '0;
            shadow[i] <= '0;
         end
         overflow   <= '0;
         snap_valid <= 1'b0;
         rd_data    <= '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            live[i]   <= live_next[i];
            shadow[i] <= shadow_next[i];
         end
         if (clear) begin
            overflow   <= '0;
            snap_valid <= 1'b0;
         end else begin
            overflow   <= overflow | ovf_set;
            snap_valid <= snap_valid | snapshot_req;
         end
         rd_data <= rd_next;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: one default instance (4 events, 32-bit,
// saturating) plus two 4-bit instances (saturating and wrapping) that share
// all inputs. Directed stimulus pushes expected readouts into a queue; a
// monitor pops and compares them one edge after each issued read.

module tb_perf_counter_bank;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic       enable;
   logic       clear;
   logic       halt_in;
   logic [3:0] event_in;
   logic       snapshot_req;
   logic [2:0] rd_sel;
   logic       rd_snap;

   // ---------------- DUT outputs ----------------
   logic [31:0] rd_data;
   logic        snap_valid;
   logic [4:0]  overflow;
   logic        running;

   logic [3:0]  rd_data_s, rd_data_w;
   logic        snap_valid_s, snap_valid_w;
   logic [4:0]  overflow_s, overflow_w;
   logic        running_s, running_w;

   perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(32), .SATURATE(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .halt_in(halt_in), .event_in(event_in), .snapshot_req(snapshot_req),
      .rd_sel(rd_sel), .rd_snap(rd_snap), .rd_data(rd_data),
      .snap_valid(snap_valid), .overflow(overflow), .running(running)
   );

   perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .halt_in(halt_in), .event_in(event_in), .snapshot_req(snapshot_req),
      .rd_sel(rd_sel), .rd_snap(rd_snap), .rd_data(rd_data_s),
      .snap_valid(snap_valid_s), .overflow(overflow_s), .running(running_s)
   );

   perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .halt_in(halt_in), .event_in(event_in), .snapshot_req(snapshot_req),
      .rd_sel(rd_sel), .rd_snap(rd_snap), .rd_data(rd_data_w),
      .snap_valid(snap_valid_w), .overflow(overflow_w), .running(running_w)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic       run;
      logic [4:0] ovf;
      logic       sv;
      logic       nar;
      logic [3:0] ds;
      logic [3:0] dw;
      logic [4:0] os;
      logic [4:0] ow;
   } flag_t;

   logic [31:0] exp_q[$];
   flag_t       flag_q[$];
   string       name_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   logic rd_issue = 1'b0;
   logic rd_pend  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] sel, input logic snp, input logic [31:0] d,
                        input flag_t f, input string nm);
      rd_sel  = sel;
      rd_snap = snp;
      exp_q.push_back(d);
      flag_q.push_back(f);
      name_q.push_back(nm);
      rd_issue = 1'b1;
      @(negedge clk);
      rd_issue = 1'b0;
   endtask

   // Read on the main instance only.
   task automatic rd(input logic [2:0] sel, input logic snp, input logic [31:0] d,
                     input logic run, input logic sv, input string nm);
      flag_t f;
      f     = '0;
      f.run = run;
      f.ovf = 5'b0;
      f.sv  = sv;
      f.nar = 1'b0;
      issue(sel, snp, d, f, nm);
   endtask

   // Read on the main instance and both 4-bit instances.
   task automatic rdn(input logic [2:0] sel, input logic snp, input logic [31:0] d,
                      input logic run, input logic sv,
                      input logic [3:0] ds, input logic [3:0] dw,
                      input logic [4:0] os, input logic [4:0] ow, input string nm);
      flag_t f;
      f.run = run;
      f.ovf = 5'b0;
      f.sv  = sv;
      f.nar = 1'b1;
      f.ds  = ds;
      f.dw  = dw;
      f.os  = os;
      f.ow  = ow;
      issue(sel, snp, d, f, nm);
   endtask

   // ---------------- monitor ----------------
   // A read issued before an edge is presented on rd_data after that edge.
   always @(posedge clk) rd_pend = rd_issue;

   always @(negedge clk) begin : monitor
      logic [31:0] d;
      flag_t       f;
      string       nm;
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL monitor_underflow: got a read with 0 expected entries, expected 1");
         end else begin
            d  = exp_q.pop_front();
            f  = flag_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".rd_data"},    64'(rd_data),    64'(d));
            chk({nm, ".running"},    64'(running),    64'(f.run));
            chk({nm, ".overflow"},   64'(overflow),   64'(f.ovf));
            chk({nm, ".snap_valid"}, 64'(snap_valid), 64'(f.sv));
            if (f.nar) begin
               chk({nm, ".sat_rd_data"},  64'(rd_data_s),  64'(f.ds));
               chk({nm, ".wrap_rd_data"}, 64'(rd_data_w),  64'(f.dw));
               chk({nm, ".sat_overflow"}, 64'(overflow_s), 64'(f.os));
               chk({nm, ".wrap_overflow"},64'(overflow_w), 64'(f.ow));
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n        = 1'b0;
      enable       = 1'b0;
      clear        = 1'b0;
      halt_in      = 1'b0;
      event_in     = 4'b0;
      snapshot_req = 1'b0;
      rd_sel       = 3'd0;
      rd_snap      = 1'b0;

      // Reset state, sampled while reset is held.
      #12;
      chk("reset.rd_data",    64'(rd_data),    64'd0);
      chk("reset.running",    64'(running),    64'd0);
      chk("reset.overflow",   64'(overflow),   64'd0);
      chk("reset.snap_valid", 64'(snap_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(3'd0, 1'b0, 32'd0, 1'b0, 1'b0, "t1_idle_cycles");

      // Test 1: 10 counted edges, ev0 every cycle, ev1 on alternate cycles.
      enable = 1'b1;
      cyc(1);                               // IDLE -> RUN, not counted
      for (int k = 0; k < 9; k++) begin
         event_in = {2'b00, (k % 2 == 0), 1'b1};
         cyc(1);
      end
      event_in = 4'b0001;                   // k = 9: ev1 idle this cycle
      rd(3'd0, 1'b0, 32'd10, 1'b1, 1'b0, "t1_cycles_run");
      enable   = 1'b0;                      // pause edge is still counted
      event_in = 4'b0;
      rd(3'd1, 1'b0, 32'd10, 1'b0, 1'b0, "t1_ev0");
      rd(3'd2, 1'b0, 32'd5,  1'b0, 1'b0, "t1_ev1");
      rd(3'd3, 1'b0, 32'd0,  1'b0, 1'b0, "t1_ev2");
      rd(3'd4, 1'b0, 32'd0,  1'b0, 1'b0, "t1_ev3");
      rd(3'd0, 1'b0, 32'd11, 1'b0, 1'b0, "t1_cycles_paused");

      // Test 2: halt freezes counts; the halt cycle itself is counted.
      enable = 1'b1;
      cyc(1);                               // IDLE -> RUN
      halt_in  = 1'b1;
      event_in = 4'b0001;
      cyc(1);                               // counted: cycles 12, ev0 11
      halt_in  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         event_in = (k % 2 == 0) ? 4'b1111 : 4'b0011;
         enable   = (k % 2 == 1);
         cyc(1);
      end
      enable   = 1'b1;
      event_in = 4'b1111;
      rd(3'd0, 1'b0, 32'd12, 1'b0, 1'b0, "t2_cycles_halted");
      rd(3'd1, 1'b0, 32'd11, 1'b0, 1'b0, "t2_ev0_halted");
      rd(3'd2, 1'b0, 32'd5,  1'b0, 1'b0, "t2_ev1_halted");
      rd(3'd3, 1'b0, 32'd0,  1'b0, 1'b0, "t2_ev2_halted");
      // clear with enable: stays IDLE, enable honoured on the next edge.
      clear = 1'b1;
      rd(3'd1, 1'b0, 32'd0, 1'b0, 1'b0, "t2_clear_with_enable");
      clear = 1'b0;
      rd(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, "t2_enable_after_clear");
      enable   = 1'b0;
      event_in = 4'b0;
      cyc(1);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;

      // Test 3: 20 ev0 pulses into 4-bit counters, saturating and wrapping.
      enable = 1'b1;
      cyc(1);                               // IDLE -> RUN
      event_in = 4'b0001;
      cyc(20);
      enable   = 1'b0;                      // cycle 21 counted, no event
      event_in = 4'b0;
      cyc(1);
      rdn(3'd1, 1'b0, 32'd20, 1'b0, 1'b0, 4'd15, 4'd4, 5'b00011, 5'b00011, "t3_ev0_overflow");
      rdn(3'd0, 1'b0, 32'd21, 1'b0, 1'b0, 4'd15, 4'd5, 5'b00011, 5'b00011, "t3_cycles_overflow");
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      rdn(3'd1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 5'b0, 5'b0, "t3_after_clear");

      // Test 4: snapshot on counted edge 6, then 10 more counted edges.
      enable   = 1'b1;
      event_in = 4'b0100;
      cyc(1);                               // IDLE -> RUN
      cyc(5);
      snapshot_req = 1'b1;
      cyc(1);                               // ev2 = 6 captured
      snapshot_req = 1'b0;
      cyc(10);                              // ev2 = 16
      enable   = 1'b0;
      event_in = 4'b0;
      cyc(1);                               // cycles = 17
      rd(3'd3, 1'b1, 32'd6,  1'b0, 1'b1, "t4_snap_ev2");
      rd(3'd3, 1'b1, 32'd6,  1'b0, 1'b1, "t4_snap_ev2_steady");
      rd(3'd3, 1'b0, 32'd16, 1'b0, 1'b1, "t4_live_ev2");
      rd(3'd0, 1'b1, 32'd6,  1'b0, 1'b1, "t4_snap_cycles");
      rd(3'd0, 1'b0, 32'd17, 1'b0, 1'b1, "t4_live_cycles");
      rd(3'd1, 1'b1, 32'd0,  1'b0, 1'b1, "t4_snap_ev0");

      // Test 5: clear and snapshot together; out-of-range select.
      clear        = 1'b1;
      snapshot_req = 1'b1;
      rd(3'd3, 1'b0, 32'd0, 1'b0, 1'b0, "t5_clear_and_snap");
      clear        = 1'b0;
      snapshot_req = 1'b0;
      enable   = 1'b1;
      event_in = 4'b1111;
      cyc(1);                               // IDLE -> RUN
      cyc(3);                               // events = 3
      enable   = 1'b0;
      event_in = 4'b0;
      cyc(1);                               // cycles = 4
      rd(3'd5, 1'b0, 32'd0, 1'b0, 1'b0, "t5_sel_out_of_range_live");
      rd(3'd5, 1'b1, 32'd0, 1'b0, 1'b0, "t5_sel_out_of_range_snap");
      rd(3'd4, 1'b0, 32'd3, 1'b0, 1'b0, "t5_ev3");
      rd(3'd0, 1'b0, 32'd4, 1'b0, 1'b0, "t5_cycles");

      // Test 6: asynchronous reset in the middle of a run.
      enable       = 1'b1;
      event_in     = 4'b1111;
      snapshot_req = 1'b1;
      cyc(1);                               // IDLE -> RUN, snap_valid set
      snapshot_req = 1'b0;
      rd(3'd0, 1'b0, 32'd5, 1'b1, 1'b1, "t6_cycles_running");
      cyc(1);                               // cycles = 6
      @(posedge clk);                       // cycles = 7
      #2;
      chk("t6_pre_reset.rd_data",    64'(rd_data),    64'd7);
      chk("t6_pre_reset.running",    64'(running),    64'd1);
      chk("t6_pre_reset.snap_valid", 64'(snap_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_reset.rd_data",    64'(rd_data),    64'd0);
      chk("t6_async_reset.running",    64'(running),    64'd0);
      chk("t6_async_reset.snap_valid", 64'(snap_valid), 64'd0);
      chk("t6_async_reset.overflow",   64'(overflow),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);                               // IDLE -> RUN
      cyc(3);
      rd(3'd0, 1'b0, 32'd4, 1'b1, 1'b0, "t6_restart_cycles");
      rd(3'd2, 1'b1, 32'd0, 1'b1, 1'b0, "t6_shadow_after_reset");
      enable   = 1'b0;
      event_in = 4'b0;
      cyc(2);

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
